// File: rtl/sram_model_pkg.sv
// Shared types and helpers for the single-port SRAM behavioural model.
// Latency: n/a (types and a pure combinational merge function only).
// Backpressure: n/a.
package sram_model_pkg;

    // Q behaviour when an access is a write
    typedef enum logic [1:0] {
        WM_READ_FIRST    = 2'd0,  // Q returns the word as it was before the write
        WM_WRITE_THROUGH = 2'd1,  // Q returns the merged post-write word
        WM_NO_READ       = 2'd2   // Q holds and no valid strobe is produced
    } write_mode_e;

    // Widest word the merge helper handles; callers zero-extend, then truncate back
    localparam int unsigned MERGE_MAX_W = 1024;

    // Masked merge: bit i takes new_dat when bweb[i] is 0, otherwise keeps old_dat
    function automatic logic [MERGE_MAX_W-1:0] sram_merge(
        input logic [MERGE_MAX_W-1:0] old_dat,
        input logic [MERGE_MAX_W-1:0] new_dat,
        input logic [MERGE_MAX_W-1:0] bweb
    );
        return (old_dat & bweb) | (new_dat & ~bweb);
    endfunction

endpackage

// File: rtl/sram_rd_pipe.sv
// Read output stage: registers read data and a one-cycle valid strobe; Q holds between reads.
// Latency: READ_LAT=1 registers at the access edge, READ_LAT=2 adds one extra stage.
// Backpressure: none; accepts one read per cycle, fully pipelined.
module sram_rd_pipe #(
    parameter int unsigned WIDTH    = 64,
    parameter int unsigned READ_LAT = 1
) (
    input  logic             CLK,
    input  logic             RSTB,
    input  logic             rd_vld,
    input  logic [WIDTH-1:0] rd_dat,
    output logic [WIDTH-1:0] q_dat,
    output logic             q_vld
);

    logic             st_vld;
    logic [WIDTH-1:0] st_dat;

    generate
        if (READ_LAT == 2) begin : g_lat2
            logic             s1_vld;
            logic [WIDTH-1:0] s1_dat;

            // Extra stage; reset drops any in-flight read so it never emerges after release
            always_ff @(posedge CLK or negedge RSTB) begin
                if (!RSTB) begin
                    s1_vld <= 1'b0;
                    s1_dat <= '0;
                end else begin
                    s1_vld <= rd_vld;
                    if (rd_vld) begin
                        s1_dat <= rd_dat;
                    end
                end
            end

            assign st_vld = s1_vld;
            assign st_dat = s1_dat;
        end else begin : g_lat1
            assign st_vld = rd_vld;
            assign st_dat = rd_dat;
        end
    endgenerate

    // Final output register: valid pulses per completed read, data holds otherwise
    always_ff @(posedge CLK or negedge RSTB) begin
        if (!RSTB) begin
            q_vld <= 1'b0;
            q_dat <= '0;
        end else begin
            q_vld <= st_vld;
            if (st_vld) begin
                q_dat <= st_dat;
            end
        end
    end

endmodule

// File: rtl/sram_sp_model.sv
// Single-port synchronous SRAM model: active-low CEB/WEB, per-bit write mask, selectable write-port read mode.
// Latency: READ_LAT (1 or 2) edges from access to Q/Q_VALID; write data readable on the next access.
// Backpressure: none; one access per cycle. Optional SRAM_MODEL_XPROP_EN enables X-propagation and range errors.
module sram_sp_model
    import sram_model_pkg::*;
#(
    parameter int unsigned WIDTH      = 64,
    parameter int unsigned DEPTH      = 512,
    parameter int unsigned ADDR_WIDTH = $clog2(DEPTH),
    parameter int unsigned READ_LAT   = 1,
    parameter write_mode_e WRITE_MODE = WM_READ_FIRST
) (
    input  logic                  CLK,
    input  logic                  RSTB,
    input  logic                  CEB,
    input  logic                  WEB,
    input  logic [ADDR_WIDTH-1:0] A,
    input  logic [WIDTH-1:0]      D,
    input  logic [WIDTH-1:0]      BWEB,
    output logic [WIDTH-1:0]      Q,
    output logic                  Q_VALID
);

    generate
        if (READ_LAT != 1 && READ_LAT != 2) begin : g_bad_lat
            $error("sram_sp_model: READ_LAT must be 1 or 2");
        end
    endgenerate

`ifdef SRAM_MODEL_XPROP_EN
    // Unwritten contents are unknown; the written flags make that explicit on reads
    logic [WIDTH-1:0] mem     [DEPTH] = '{default: 'x};
    logic             written [DEPTH] = '{default: 1'b0};
    logic             ctrl_x;
    assign ctrl_x = $isunknown({CEB, WEB});
`else
    // Array is not touched by reset; it starts out all zeros
    logic [WIDTH-1:0] mem [DEPTH] = '{default: '0};
`endif

    logic             acc;
    logic             in_range;
    logic [WIDTH-1:0] cur_word;
    logic [WIDTH-1:0] merged;
    logic             rd_vld;
    logic [WIDTH-1:0] rd_dat;

    assign acc      = !CEB;
    assign in_range = (32'(A) < DEPTH);
    assign cur_word = in_range ? mem[A] : '0;
    assign merged   = WIDTH'(sram_merge(MERGE_MAX_W'(cur_word), MERGE_MAX_W'(D), MERGE_MAX_W'(BWEB)));

    // Decide whether this access produces a read result and which word it returns
    always_comb begin
        rd_vld = 1'b0;
        rd_dat = '0;
        if (acc) begin
            if (WEB) begin
                rd_vld = 1'b1;
                rd_dat = cur_word;
            end else if (WRITE_MODE != WM_NO_READ) begin
                rd_vld = 1'b1;
                rd_dat = (WRITE_MODE == WM_WRITE_THROUGH) ? merged : cur_word;
            end
            // Out-of-range accesses always read back as zeros
            if (!in_range) begin
                rd_dat = '0;
            end
        end
`ifdef SRAM_MODEL_XPROP_EN
        if (ctrl_x) begin
            rd_vld = 1'b1;
            rd_dat = 'x;
        end else if (rd_vld && (!in_range || !written[A])) begin
            rd_dat = 'x;
        end
`endif
    end

    // Array update: masked write to in-range addresses only
    always_ff @(posedge CLK) begin
        if (acc && !WEB && in_range) begin
            mem[A] <= merged;
        end
`ifdef SRAM_MODEL_XPROP_EN
        if (acc && !WEB && in_range) begin
            written[A] <= 1'b1;
        end
        if (ctrl_x && in_range) begin
            mem[A]     <= 'x;
            written[A] <= 1'b1;
        end
        if (acc && !in_range) begin
            $error("sram_sp_model: access to out-of-range address %0d (DEPTH %0d)", A, DEPTH);
        end
`endif
    end

    sram_rd_pipe #(
        .WIDTH    (WIDTH),
        .READ_LAT (READ_LAT)
    ) u_rd_pipe (
        .CLK    (CLK),
        .RSTB   (RSTB),
        .rd_vld (rd_vld),
        .rd_dat (rd_dat),
        .q_dat  (Q),
        .q_vld  (Q_VALID)
    );

endmodule

// File: tb/tb_sram_sp_model.sv
// Bench for sram_sp_model: three configurations share one stimulus stream and a queue-based reference.
// Latency: checks Q/Q_VALID 1ns after every rising edge against results scheduled READ_LAT-1 edges ahead.
// Backpressure: n/a.
module tb_sram_sp_model;
    import sram_model_pkg::*;

    localparam int W   = 64;
    localparam int DEP = 500;
    localparam int AW  = 9;
    localparam int NI  = 3;

    // Instance 0: READ_FIRST lat 1, instance 1: WRITE_THROUGH lat 2, instance 2: NO_READ lat 1
    localparam int          LAT  [NI] = '{1, 2, 1};
    localparam write_mode_e MODE [NI] = '{WM_READ_FIRST, WM_WRITE_THROUGH, WM_NO_READ};

    logic          CLK = 1'b0;
    logic          RSTB;
    logic          CEB;
    logic          WEB;
    logic [AW-1:0] A;
    logic [W-1:0]  D;
    logic [W-1:0]  BWEB;
    logic [W-1:0]  q_o  [NI];
    logic          qv_o [NI];

    always #5 CLK = ~CLK;

    sram_sp_model #(.WIDTH(W), .DEPTH(DEP), .READ_LAT(1), .WRITE_MODE(WM_READ_FIRST)) u_rf (
        .CLK(CLK), .RSTB(RSTB), .CEB(CEB), .WEB(WEB), .A(A), .D(D), .BWEB(BWEB),
        .Q(q_o[0]), .Q_VALID(qv_o[0]));
    sram_sp_model #(.WIDTH(W), .DEPTH(DEP), .READ_LAT(2), .WRITE_MODE(WM_WRITE_THROUGH)) u_wt (
        .CLK(CLK), .RSTB(RSTB), .CEB(CEB), .WEB(WEB), .A(A), .D(D), .BWEB(BWEB),
        .Q(q_o[1]), .Q_VALID(qv_o[1]));
    sram_sp_model #(.WIDTH(W), .DEPTH(DEP), .READ_LAT(1), .WRITE_MODE(WM_NO_READ)) u_nr (
        .CLK(CLK), .RSTB(RSTB), .CEB(CEB), .WEB(WEB), .A(A), .D(D), .BWEB(BWEB),
        .Q(q_o[2]), .Q_VALID(qv_o[2]));

    // Reference: flat word array plus, per instance, a queue of results tagged with their due edge
    typedef struct {
        int          due;
        logic [63:0] dat;
    } res_t;

    logic [63:0] mdl    [DEP];
    res_t        pend   [NI][$];
    logic [63:0] exp_q  [NI];
    logic        exp_qv [NI];
    int          cyc;
    int          n_chk;
    int          n_pass;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            $display("FAIL %s at edge %0d: got %h expected %h", tag, cyc, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < NI; i++) begin
            chk($sformatf("Q[%0d]", i), q_o[i], exp_q[i]);
            chk($sformatf("Q_VALID[%0d]", i), 64'(qv_o[i]), 64'(exp_qv[i]));
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NI; i++) begin
            pend[i].delete();
            exp_q[i]  = '0;
            exp_qv[i] = 1'b0;
        end
    endtask

    // One access as the spec describes it: schedule what each instance must deliver, then update the array
    task automatic model_access(input logic web, input logic [AW-1:0] a,
                                input logic [63:0] d, input logic [63:0] bweb);
        bit          inr;
        logic [63:0] old_w;
        logic [63:0] new_w;
        logic [63:0] ret;
        inr   = (int'(a) < DEP);
        old_w = inr ? mdl[a] : 64'd0;
        new_w = (old_w & bweb) | (d & ~bweb);
        for (int i = 0; i < NI; i++) begin
            if (web || MODE[i] != WM_NO_READ) begin
                ret = (!web && MODE[i] == WM_WRITE_THROUGH) ? new_w : old_w;
                if (!inr) ret = 64'd0;
                pend[i].push_back('{cyc + LAT[i] - 1, ret});
            end
        end
        if (!web && inr) mdl[a] = new_w;
    endtask

    // Drive one cycle of inputs, advance the reference at the edge, and check just after it
    task automatic step(input logic ceb, input logic web, input logic [AW-1:0] a,
                        input logic [63:0] d, input logic [63:0] bweb);
        CEB  = ceb;
        WEB  = web;
        A    = a;
        D    = d;
        BWEB = bweb;
        @(posedge CLK);
        cyc++;
        if (!ceb) model_access(web, a, d, bweb);
        for (int i = 0; i < NI; i++) begin
            exp_qv[i] = 1'b0;
            if (pend[i].size() > 0 && pend[i][0].due == cyc) begin
                exp_q[i]  = pend[i][0].dat;
                exp_qv[i] = 1'b1;
                void'(pend[i].pop_front());
            end
        end
        #1;
        check_all();
    endtask

    task automatic idle();
        step(1'b1, 1'b1, '0, '0, '1);
    endtask

    initial begin
        logic          r_ceb;
        logic          r_web;
        logic [AW-1:0] r_a;
        logic [63:0]   r_d;
        logic [63:0]   r_bweb;

        n_chk  = 0;
        n_pass = 0;
        cyc    = 0;
        for (int k = 0; k < DEP; k++) mdl[k] = 64'd0;
        model_reset();

        RSTB = 1'b0;
        CEB  = 1'b1;
        WEB  = 1'b1;
        A    = '0;
        D    = '0;
        BWEB = '1;
        repeat (3) @(posedge CLK);
        #1;
        check_all();
        @(negedge CLK);
        RSTB = 1'b1;

        // Full write then read back
        step(1'b0, 1'b0, 9'h005, 64'hDEADBEEF_CAFEF00D, 64'h0);
        step(1'b0, 1'b1, 9'h005, 64'h0, '1);
        idle();
        idle();

        // Masked write of the low half only
        step(1'b0, 1'b0, 9'h005, 64'h0, 64'hFFFFFFFF_00000000);
        step(1'b0, 1'b1, 9'h005, 64'h0, '1);
        idle();
        idle();

        // Write over existing word exercises each write-port read mode
        step(1'b0, 1'b0, 9'h003, 64'h2222, 64'h0);
        step(1'b0, 1'b0, 9'h003, 64'h1111, 64'h0);
        idle();
        idle();

        // Back-to-back reads through the pipeline
        step(1'b0, 1'b0, 9'h001, 64'hAAAA_0001, 64'h0);
        step(1'b0, 1'b0, 9'h002, 64'hBBBB_0002, 64'h0);
        step(1'b0, 1'b1, 9'h001, 64'h0, '1);
        step(1'b0, 1'b1, 9'h002, 64'h0, '1);
        step(1'b0, 1'b1, 9'h003, 64'h0, '1);
        idle();
        idle();

        // Reset lands while a two-stage read is still in flight
        step(1'b0, 1'b1, 9'h002, 64'h0, '1);
        CEB  = 1'b1;
        RSTB = 1'b0;
        #1;
        model_reset();
        check_all();
        @(posedge CLK);
        cyc++;
        #1;
        check_all();
        @(negedge CLK);
        RSTB = 1'b1;
        idle();
        idle();
        step(1'b0, 1'b1, 9'h005, 64'h0, '1);
        idle();
        idle();

        // Last legal word and an address beyond DEPTH
        step(1'b0, 1'b0, 9'd499, 64'h0123_4567_89AB_CDEF, 64'h0);
        step(1'b0, 1'b1, 9'd499, 64'h0, '1);
        step(1'b0, 1'b0, 9'd510, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0);
        step(1'b0, 1'b1, 9'd510, 64'h0, '1);
        idle();
        idle();

        // Random traffic concentrated on a few addresses plus some out-of-range ones
        for (int n = 0; n < 400; n++) begin
            r_ceb = ($urandom_range(0, 3) == 0);
            r_web = ($urandom_range(0, 1) == 1);
            r_a   = ($urandom_range(0, 7) == 0) ? AW'($urandom_range(DEP, 511))
                                                : AW'($urandom_range(0, 15));
            r_d   = {$urandom, $urandom};
            case ($urandom_range(0, 2))
                0:       r_bweb = 64'h0;
                1:       r_bweb = '1;
                default: r_bweb = {$urandom, $urandom};
            endcase
            step(r_ceb, r_web, r_a, r_d, r_bweb);
        end
        idle();
        idle();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/sram_sp_model.md
# sram_sp_model

Parametrised behavioural model of a single-port synchronous SRAM macro with active-low chip enable, write enable and per-bit write mask. It generalises the fixed 512x64 macro model to arbitrary width/depth and adds a selectable write-port read mode, a 1- or 2-cycle read pipeline with a valid strobe, and reset of the output path. It sits under the memory-core tile wrappers as the simulation stand-in for any single-port macro.

## Interface
- WIDTH, 64: data word width in bits.
- DEPTH, 512: number of words; need not be a power of two.
- ADDR_WIDTH, $clog2(DEPTH): address width.
- READ_LAT, 1: read latency in cycles, legal values 1 or 2.
- WRITE_MODE, WM_READ_FIRST: Q behaviour on a write access (see Operation).

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RSTB  in  1  asynchronous active-low reset.
- CEB  in  1  chip enable, active low.
- WEB  in  1  write enable, active low; meaningful only when CEB=0.
- A  in  ADDR_WIDTH  word address.
- D  in  WIDTH  write data.
- BWEB  in  WIDTH  per-bit write mask, active low (bit i written when BWEB[i]=0).
- Q  out  WIDTH  read data.
- Q_VALID  out  1  high for exactly one cycle when Q carries newly read data.

## Operation
- Access = rising CLK with CEB=0. CEB=1: array unchanged, no new read issued.
- Write (WEB=0): for each bit i with BWEB[i]=0, mem[A][i] <= D[i]; other bits keep value. BWEB all ones = write with no bit change.
- Read (WEB=1): fetch mem[A].
- WRITE_MODE on write access:
  - WM_READ_FIRST: Q returns pre-write word; Q_VALID asserted.
  - WM_WRITE_THROUGH: Q returns post-merge word; Q_VALID asserted.
  - WM_NO_READ: Q holds previous value; Q_VALID not asserted.
- Q holds last delivered value whenever no read completes.
- Out-of-range address (A >= DEPTH): write ignored; read returns all zeros with Q_VALID asserted.
- Reset: Q = 0, Q_VALID = 0, read pipeline cleared. Array contents are NOT affected by reset. Reset asserted mid-access discards in-flight reads; no Q_VALID for them after release.
- Array initialised to all zeros at time 0 (unless macro below is defined).

## Timing
- READ_LAT=1: access at edge N -> Q/Q_VALID update at edge N (visible during cycle N..N+1).
- READ_LAT=2: one extra register stage; Q/Q_VALID update at edge N+1. Back-to-back reads fully pipelined, one result per cycle.
- Write data visible to a read issued on the next access edge (read-after-write, same address, consecutive cycles, returns new data).
- Q_VALID is a single-cycle pulse per completed read; consecutive reads give continuous Q_VALID high.
- RSTB deassertion synchronous use: first access honoured on first rising edge with RSTB=1.

## Configuration
- SRAM_MODEL_XPROP_EN defined: per-word written flag tracked; reads of never-written words return all X; out-of-range reads return all X; X/Z on CEB or WEB at an edge sets Q to X and corrupts the addressed word to X; $error reported for out-of-range access.
- Not defined: array zero-initialised, no X generation, no messages; behaviour exactly as in Operation.

## Structure
- Package sram_model_pkg: write_mode_e enum (WM_READ_FIRST, WM_WRITE_THROUGH, WM_NO_READ), function for masked word merge.
- Sub-module sram_rd_pipe: parametrised (WIDTH, READ_LAT) output stage holding Q/Q_VALID, async reset, hold when no read.
- Top holds array, address range check, write merge, mode selection; elaboration error if READ_LAT not in {1,2}.

## Test plan
- Write A=0x005 D=0xDEADBEEF_CAFEF00D BWEB=0, then read A=0x005 -> Q=0xDEADBEEF_CAFEF00D, Q_VALID one cycle, at edge per READ_LAT.
- Masked write A=0x005 D=0 BWEB=0xFFFFFFFF_00000000 over prior word -> subsequent read Q=0xDEADBEEF_00000000.
- WM_READ_FIRST vs WM_WRITE_THROUGH vs WM_NO_READ: write 0x1111 over 0x2222 at A=3 -> Q=0x2222 / 0x1111 / held with Q_VALID=0.
- READ_LAT=2, reads A=1,2,3 back-to-back -> Q_VALID high 3 consecutive cycles starting one edge after first access, data in order.
- RSTB low for 1 cycle during pipelined read -> Q=0, Q_VALID=0, no stale Q_VALID after release; prior array contents still readable.
- DEPTH=500, write/read A=510 -> array unchanged, Q=0 (X and $error with SRAM_MODEL_XPROP_EN).
